rr_hold_arbiter: RTL
====================

Name: rr_hold_arbiter

Overview:
- Round-robin arbiter that shares one resource among N requesters.
- Grants one requester at a time. Each grant is bounded by a hold limit: the owner is pre-empted when other requesters are waiting.
- Its small control FSM pairs with the team's property-checking models. Outputs p/q give simple observables for model-checking properties and counterexample traces.

Parameters:
- N, 4, number of requesters (2..8).
- MAXHOLD, 4, max consecutive grant cycles when others are waiting (2..2^CW).
- CW, 3, hold-counter width.

Ports:
- clock  input  1  sole clock, rising edge.
- reset_n  input  1  synchronous, active-low reset.
- req  input  N  request per requester; level, held until done.
- grant  output  N  one-hot registered grant, all-zero when idle.
- owner  output  $clog2(N)  index of current owner; 0 when idle.
- busy  output  1  any grant active (= |grant).
- p  output  1  equals busy.
- q  output  1  one-cycle pulse in the cycle after a pre-emption edge.
- starve  output  1  sticky starvation flag (see Optional Feature).

Behaviour:
- Reset:
  - reset_n sampled low at an edge → state=IDLE, grant=0, owner=0, busy=p=q=0, ptr=0, hold=0, starve=0.
  - Reset overrides every other event, including a grant in progress.
- State IDLE:
  - If req≠0, pick the first set bit searching cyclically from ptr (ptr, ptr+1, … mod N).
  - Next edge: grant=onehot(winner), owner=winner, hold=0, state=GRANT. Latency req→grant is 1 cycle.
  - If req=0, stay in IDLE.
- State GRANT (per edge, in this priority order):
  1. Release: req[owner]=0 → grant=0, owner=0, ptr=(owner+1) mod N, hold=0, state=IDLE. There is always ≥1 dead cycle between owners.
  2. Pre-emption: hold==MAXHOLD-1, req[owner]=1, and (req & ~grant)≠0 → grant=0, owner=0, ptr=(owner+1) mod N, hold=0, q=1 for next cycle, state=IDLE. The owner therefore holds for exactly MAXHOLD cycles.
  3. Otherwise: keep grant. hold=min(hold+1, MAXHOLD-1), i.e. it saturates with no competitors. The owner may then hold indefinitely while alone.
- Simultaneous release and limit on the same edge: release wins; q stays 0.
- New requests arriving during GRANT do not affect the grant until the limit is reached.
- ptr wraps N-1 → 0.
- q:
  - Registered; high for exactly one cycle per pre-emption.
  - Never high while grant≠0.
  - Never high on two consecutive cycles.
- Invariants:
  - grant is one-hot or zero.
  - grant[k]=1 implies req[k] was 1 at the preceding edge.
  - busy==p==|grant.
- All outputs are registered; there are no combinational paths from req to outputs.

Optional Feature:
- Macro ARB_STARVE_CHK_EN.
- Defined:
  - Per-requester wait counters, width $clog2(N*(MAXHOLD+1)+1)+1.
  - Counter k increments each cycle req[k]=1 && grant[k]=0; it clears when grant[k]=1 or req[k]=0.
  - starve sets at the edge any counter exceeds N*(MAXHOLD+1). It is sticky until reset.
  - A correct arbiter never sets starve; it is a checker for properties.
- Undefined: no counters; starve tied to 0.

Test Plan (N=4, MAXHOLD=4, CW=3):
1. reset_n=0 for 2 edges with req=4'b1111 → grant=0, busy=p=q=0. Raise reset_n → grant=4'b0001 one edge later, owner=0.
2. Only req[2] held for 10 cycles → grant=4'b0100 for all 10 cycles after the 1-cycle latency; q never pulses; hold saturates at 3.
3. req=4'b0011 held continuously → repeating sequence:
   - grant 0001 for 4 cycles;
   - 1 idle cycle with q=1;
   - grant 0010 for 4 cycles;
   - idle with q=1;
   - back to 0001.
4. req[1] granted; drop req[1] after 2 grant cycles while req[3] rises that same cycle → grant=0 for 1 cycle (q=0), then grant=4'b1000, ptr stepped past 1.
5. req=4'b0101 and owner 0 drops req[0] on the edge where hold==3 → no q pulse; next owner is 2.
6. With a grant to owner 3 active, assert reset_n=0 for one edge → grant=0, owner=0, ptr=0. With req=4'b1001 after reset, requester 0 wins. With ARB_STARVE_CHK_EN, scenario 3 run for 200 cycles leaves starve=0.

Source files
------------

// File: rtl/rr_hold_arbiter.sv
// Round-robin arbiter with a per-grant hold limit and pre-emption pulse (q).
// Optional sticky starvation checker enabled by defining ARB_STARVE_CHK_EN.
module rr_hold_arbiter #(
    parameter int N       = 4,
    parameter int MAXHOLD = 4,
    parameter int CW      = 3
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [N-1:0]         req,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] owner,
    output logic                 busy,
    output logic                 p,
    output logic                 q,
    output logic                 starve
);

    localparam int PW = $clog2(N);
    localparam logic [CW-1:0] HOLD_LIM = CW'(MAXHOLD - 1);
    localparam logic [CW-1:0] HOLD_ONE = CW'(1);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [N-1:0]    grant_q, grant_d;
    logic [PW-1:0]   owner_q, owner_d;
    logic [PW-1:0]   ptr_q,   ptr_d;
    logic [CW-1:0]   hold_q,  hold_d;
    logic            q_q,     q_d;
    logic            starve_q;
    logic [PW-1:0]   win_s;

    // First requester at or after ptr, searching cyclically.
    function automatic logic [PW-1:0] pick_winner(input logic [N-1:0] r, input logic [PW-1:0] start);
        logic [PW-1:0] w;
        logic [PW-1:0] cand;
        logic          found;
        w     = {PW{1'b0}};
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            cand = PW'((int'(start) + k) % N);
            if (!found && r[cand]) begin
                w     = cand;
                found = 1'b1;
            end else begin
                w     = w;
                found = found;
            end
        end
        return w;
    endfunction

    function automatic logic [PW-1:0] inc_idx(input logic [PW-1:0] i);
        return (i == PW'(N - 1)) ? {PW{1'b0}} : i + PW'(1);
    endfunction

    assign win_s = pick_winner(req, ptr_q);

    // State and datapath registers.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            grant_q <= {N{1'b0}};
            owner_q <= {PW{1'b0}};
            ptr_q   <= {PW{1'b0}};
            hold_q  <= {CW{1'b0}};
            q_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
            q_q     <= q_d;
        end
    end

    // Next-state logic: release beats pre-emption beats holding.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        q_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (|req) begin
                    grant_d = {{(N-1){1'b0}}, 1'b1} << win_s;
                    owner_d = win_s;
                    hold_d  = {CW{1'b0}};
                    state_d = S_GRANT;
                end else begin
                    grant_d = {N{1'b0}};
                    owner_d = {PW{1'b0}};
                    hold_d  = {CW{1'b0}};
                end
            end
            S_GRANT: begin
                if (!req[owner_q]) begin
                    grant_d = {N{1'b0}};
                    owner_d = {PW{1'b0}};
                    ptr_d   = inc_idx(owner_q);
                    hold_d  = {CW{1'b0}};
                    state_d = S_IDLE;
                end else if ((hold_q == HOLD_LIM) && (|(req & ~grant_q))) begin
                    grant_d = {N{1'b0}};
                    owner_d = {PW{1'b0}};
                    ptr_d   = inc_idx(owner_q);
                    hold_d  = {CW{1'b0}};
                    q_d     = 1'b1;
                    state_d = S_IDLE;
                end else if (hold_q != HOLD_LIM) begin
                    hold_d = hold_q + HOLD_ONE;
                end else begin
                    hold_d = hold_q;
                end
            end
            default: begin
                state_d = S_IDLE;
                grant_d = {N{1'b0}};
                owner_d = {PW{1'b0}};
                hold_d  = {CW{1'b0}};
            end
        endcase
    end

`ifdef ARB_STARVE_CHK_EN
    localparam int WW = $clog2(N * (MAXHOLD + 1) + 1) + 1;
    localparam logic [WW-1:0] WAIT_LIM = WW'(N * (MAXHOLD + 1));

    logic [WW-1:0] wait_q [N];
    logic [WW-1:0] wait_d [N];
    logic          starve_d;

    // Wait counters run while a requester is pending without a grant.
    always_comb begin
        wait_d   = wait_q;
        starve_d = starve_q;
        for (int k = 0; k < N; k++) begin
            if (req[k] && !grant_q[k]) begin
                wait_d[k] = (wait_q[k] != {WW{1'b1}}) ? wait_q[k] + WW'(1) : wait_q[k];
            end else begin
                wait_d[k] = {WW{1'b0}};
            end
            starve_d = starve_d | (wait_d[k] > WAIT_LIM);
        end
    end

    // Starvation checker registers; starve is sticky until reset.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            for (int k = 0; k < N; k++) begin
                wait_q[k] <= {WW{1'b0}};
            end
            starve_q <= 1'b0;
        end else begin
            wait_q   <= wait_d;
            starve_q <= starve_d;
        end
    end
`else
    assign starve_q = 1'b0;
`endif

    // Outputs are straight copies of registered state.
    always_comb begin
        grant  = grant_q;
        owner  = owner_q;
        busy   = |grant_q;
        p      = |grant_q;
        q      = q_q;
        starve = starve_q;
    end

endmodule
